// File: rtl/ethernet_pkg.sv
// ethernet_pkg: Ethernet II framing constants shared by the MAC-side blocks.
package ethernet_pkg;
    localparam int          ETH_HDR_LEN = 14;
    localparam logic [15:0] ETH_P_IP    = 16'h0800;
endpackage

// File: rtl/ip_pkg.sv
// ip_pkg: IPv4 framing constants.
package ip_pkg;
    localparam int         IP4_HDR_LEN   = 20;
    localparam logic [7:0] IP4_PROTO_UDP = 8'd17;
endpackage

// File: rtl/pcie_tcap_pkg.sv
// pcie_tcap_pkg: shared definitions for the TCAP encapsulator / decapsulator.
//   - wire byte offsets of the checked header fields
//   - receive state enum
//   - 74-bit TLP FIFO word {tkeep, tdata, tlast, tuser}
//   - hdr_byte(): pull wire byte 'off' out of the 64-bit beat carrying it
package pcie_tcap_pkg;
    import ethernet_pkg::*;
    import ip_pkg::*;
    import udp_pkg::*;

    localparam int TCAP_HDR_LEN = 6;
    localparam int HDR_LEN      = ETH_HDR_LEN + IP4_HDR_LEN + UDP_HDR_LEN + TCAP_HDR_LEN;
    localparam int HDR_BEATS    = HDR_LEN / 8;

    localparam int OFF_ETH_DST   = 0;
    localparam int OFF_ETH_TYPE  = 12;
    localparam int OFF_IP_VIHL   = 14;
    localparam int OFF_IP_PROTO  = 23;
    localparam int OFF_IP_DADDR  = 30;
    localparam int OFF_UDP_DPORT = 36;
    localparam int OFF_TCAP_VER  = 42;
    localparam int OFF_TCAP_SEQ  = 43;

    // version 4, 20-byte header (no options)
    localparam logic [7:0] IP4_VER_IHL = 8'h45;

    typedef enum logic [1:0] {
        RX_HDR  = 2'd0,
        RX_DATA = 2'd1,
        RX_DROP = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [7:0]  tkeep;
        logic [63:0] tdata;
        logic        tlast;
        logic        tuser;
    } tlp_word_t;

    function automatic logic [7:0] hdr_byte(input logic [63:0] d, input int off);
        return d[8*(off%8) +: 8];
    endfunction
endpackage

// File: rtl/udp_pkg.sv
// udp_pkg: UDP framing constants.
package udp_pkg;
    localparam int UDP_HDR_LEN = 8;
endpackage

// File: rtl/eth_decap_hdrchk.sv
// eth_decap_hdrchk: combinational per-beat header check.
//   beat_idx  in   index (0..5) of the header beat presented on tdata
//   tdata     in   beat data, wire byte 0 in [7:0]
//   beat_ok   out  all fields carried by this beat match
//   seq       out  TCAP 40-bit sequence number (meaningful on beat 5)
// Fields split across beats (IPv4 daddr) are checked half per beat.
module eth_decap_hdrchk
    import ethernet_pkg::*, ip_pkg::*, pcie_tcap_pkg::*;
#(
    parameter logic [47:0] ETH_ADDR  = 48'h00_11_22_33_44_55,
    parameter logic [15:0] ETH_PROTO = ETH_P_IP,
    parameter logic [31:0] IP_ADDR   = {8'd192, 8'd168, 8'd11, 8'd1},
    parameter logic [15:0] UDP_PORT  = 16'h3776,
    parameter logic [2:0]  TCAP_VER  = 3'b001
) (
    input  logic [2:0]  beat_idx,
    input  logic [63:0] tdata,
    output logic        beat_ok,
    output logic [39:0] seq
);
    logic [47:0] dst;
    logic [7:0]  ver_b;

    assign dst = {hdr_byte(tdata, OFF_ETH_DST+0), hdr_byte(tdata, OFF_ETH_DST+1),
                  hdr_byte(tdata, OFF_ETH_DST+2), hdr_byte(tdata, OFF_ETH_DST+3),
                  hdr_byte(tdata, OFF_ETH_DST+4), hdr_byte(tdata, OFF_ETH_DST+5)};

    assign ver_b = hdr_byte(tdata, OFF_TCAP_VER);

    // big-endian on the wire: lowest offset is the MSB
    assign seq = {hdr_byte(tdata, OFF_TCAP_SEQ+0), hdr_byte(tdata, OFF_TCAP_SEQ+1),
                  hdr_byte(tdata, OFF_TCAP_SEQ+2), hdr_byte(tdata, OFF_TCAP_SEQ+3),
                  hdr_byte(tdata, OFF_TCAP_SEQ+4)};

    always_comb begin
        beat_ok = 1'b0;
        case (beat_idx)
            3'd0: beat_ok = (dst == ETH_ADDR) || (dst == 48'hFFFF_FFFF_FFFF);
            3'd1: beat_ok = ({hdr_byte(tdata, OFF_ETH_TYPE), hdr_byte(tdata, OFF_ETH_TYPE+1)} == ETH_PROTO)
                         && (hdr_byte(tdata, OFF_IP_VIHL) == IP4_VER_IHL);
            3'd2: beat_ok = (hdr_byte(tdata, OFF_IP_PROTO) == IP4_PROTO_UDP);
            3'd3: beat_ok = ({hdr_byte(tdata, OFF_IP_DADDR), hdr_byte(tdata, OFF_IP_DADDR+1)} == IP_ADDR[31:16]);
            3'd4: beat_ok = ({hdr_byte(tdata, OFF_IP_DADDR+2), hdr_byte(tdata, OFF_IP_DADDR+3)} == IP_ADDR[15:0])
                         && ({hdr_byte(tdata, OFF_UDP_DPORT), hdr_byte(tdata, OFF_UDP_DPORT+1)} == UDP_PORT);
            3'd5: beat_ok = (ver_b[7:5] == TCAP_VER);
            default: beat_ok = 1'b0;
        endcase
    end
endmodule

// File: rtl/eth_decap.sv
// eth_decap: 10G RX decapsulator. Checks the 48-byte Eth+IPv4+UDP+TCAP
// header, strips it, and writes payload beats into the TLP FIFO.
//   clk156, sys_rst_n            clock, async active-low reset
//   s_axis_t{valid,ready,data,keep,last,user}  MAC RX stream
//   wr_en, din, full             TLP FIFO write port (74-bit tlp_word_t)
//   drop_count                   dropped frames (bad header or runt)
//   seq_gap_count                only with ETH_DECAP_SEQCHK_EN: count of
//                                accepted frames whose TCAP seq skipped
// Optional feature macro: ETH_DECAP_SEQCHK_EN.
module eth_decap
    import ethernet_pkg::*, ip_pkg::*, pcie_tcap_pkg::*;
#(
    parameter logic [47:0] eth_addr  = 48'h00_11_22_33_44_55,
    parameter logic [15:0] eth_proto = ETH_P_IP,
    parameter logic [31:0] ip_addr   = {8'd192, 8'd168, 8'd11, 8'd1},
    parameter logic [15:0] udp_port  = 16'h3776,
    parameter logic [2:0]  tcap_ver  = 3'b001
) (
    input  logic        clk156,
    input  logic        sys_rst_n,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        wr_en,
    output logic [73:0] din,
    input  logic        full,
`ifdef ETH_DECAP_SEQCHK_EN
    output logic [31:0] seq_gap_count,
`endif
    output logic [31:0] drop_count
);
    localparam logic [2:0] LAST_HDR_BEAT = 3'(HDR_BEATS - 1);

    rx_state_t   state, state_nxt;
    logic [2:0]  beat_cnt, beat_cnt_nxt;
    logic        hdr_ok, hdr_ok_nxt;
    logic        out_en;      // holds tready low until the first edge after reset
    logic        drop_inc;
    logic        enter_data;
    logic        beat_ok;
    logic [39:0] seq;
    logic        acc;
    logic        hdr_run;
    tlp_word_t   word;

    eth_decap_hdrchk #(
        .ETH_ADDR  (eth_addr),
        .ETH_PROTO (eth_proto),
        .IP_ADDR   (ip_addr),
        .UDP_PORT  (udp_port),
        .TCAP_VER  (tcap_ver)
    ) u_hdrchk (
        .beat_idx (beat_cnt),
        .tdata    (s_axis_tdata),
        .beat_ok  (beat_ok),
        .seq      (seq)
    );

    assign acc     = s_axis_tvalid && s_axis_tready;
    // running AND of per-beat results; beat 0 starts a fresh frame
    assign hdr_run = ((beat_cnt == 3'd0) || hdr_ok) && beat_ok;

    assign word = '{tkeep: s_axis_tkeep, tdata: s_axis_tdata,
                    tlast: s_axis_tlast, tuser: s_axis_tuser};

    always_comb begin
        state_nxt     = state;
        beat_cnt_nxt  = beat_cnt;
        hdr_ok_nxt    = hdr_ok;
        drop_inc      = 1'b0;
        enter_data    = 1'b0;
        s_axis_tready = 1'b0;
        wr_en         = 1'b0;
        din           = '0;
        case (state)
            RX_HDR: begin
                s_axis_tready = out_en;
                if (acc) begin
                    hdr_ok_nxt = hdr_run;
                    if (s_axis_tlast) begin
                        // runt, including a bare 48-byte header
                        drop_inc     = 1'b1;
                        beat_cnt_nxt = 3'd0;
                    end else if (beat_cnt == LAST_HDR_BEAT) begin
                        beat_cnt_nxt = 3'd0;
                        if (hdr_run) begin
                            state_nxt  = RX_DATA;
                            enter_data = 1'b1;
                        end else begin
                            state_nxt  = RX_DROP;
                        end
                    end else begin
                        beat_cnt_nxt = beat_cnt + 3'd1;
                    end
                end
            end
            RX_DATA: begin
                // ready and write strobe are the same condition, so every
                // accepted beat is written exactly once
                s_axis_tready = !full;
                wr_en         = s_axis_tvalid && !full;
                din           = word;
                if (acc && s_axis_tlast) state_nxt = RX_HDR;
            end
            RX_DROP: begin
                s_axis_tready = 1'b1;
                if (acc && s_axis_tlast) begin
                    drop_inc  = 1'b1;
                    state_nxt = RX_HDR;
                end
            end
            default: state_nxt = RX_HDR;
        endcase
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= RX_HDR;
            beat_cnt   <= 3'd0;
            hdr_ok     <= 1'b0;
            out_en     <= 1'b0;
            drop_count <= 32'd0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            hdr_ok   <= hdr_ok_nxt;
            out_en   <= 1'b1;
            if (drop_inc) drop_count <= drop_count + 32'd1;
        end
    end

`ifdef ETH_DECAP_SEQCHK_EN
    logic [39:0] last_seq;
    logic        have_prev;

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_seq      <= 40'd0;
            have_prev     <= 1'b0;
            seq_gap_count <= 32'd0;
        end else if (enter_data) begin
            if (have_prev && (seq != last_seq + 40'd1))
                seq_gap_count <= seq_gap_count + 32'd1;
            last_seq  <= seq;
            have_prev <= 1'b1;
        end
    end
`else
    logic unused_seq;
    assign unused_seq = ^seq;
`endif
endmodule

// File: tb/tb_eth_decap.sv
module tb_eth_decap;
    localparam logic [47:0] MAC   = 48'h00_11_22_33_44_55;
    localparam logic [31:0] IPA   = {8'd192, 8'd168, 8'd11, 8'd1};
    localparam logic [15:0] UPORT = 16'h3776;

    logic        clk156 = 1'b0;
    logic        sys_rst_n;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        wr_en;
    logic [73:0] din;
    logic        full;
    logic [31:0] drop_count;
`ifdef ETH_DECAP_SEQCHK_EN
    logic [31:0] seq_gap_count;
`endif

    always #5 clk156 = ~clk156;

    eth_decap dut (
        .clk156        (clk156),
        .sys_rst_n     (sys_rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .wr_en         (wr_en),
        .din           (din),
        .full          (full),
`ifdef ETH_DECAP_SEQCHK_EN
        .seq_gap_count (seq_gap_count),
`endif
        .drop_count    (drop_count)
    );

    int          total = 0;
    int          bad   = 0;
    int          viol  = 0;
    int          model_drop = 0;
    int          m_gaps = 0;
    bit          m_prev = 0;
    logic [39:0] m_last = '0;
    logic [39:0] sq_next;
    logic [7:0]  fb[$];
    int          nb;
    logic [7:0]  lkeep;
    logic        luser;
    logic [73:0] got[$];
    logic [73:0] exp_q[$];
    bit          rnd_gaps = 0;
    bit          rnd_full = 0;

    // every FIFO write the DUT makes, in order; a write with full high or
    // without a valid beat is a protocol violation
    always @(negedge clk156) begin
        if (wr_en === 1'b1) begin
            got.push_back(din);
            if (full !== 1'b0 || s_axis_tvalid !== 1'b1) viol++;
        end
    end

    task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk156);
            #1;
        end
    endtask

    // kind: 0 valid, 1 bad dmac, 2 broadcast, 3 bad ethertype, 4 bad ver/ihl,
    //       5 bad proto, 6 bad daddr, 7 bad dport, 8 bad tcap ver
    task automatic build(input int kind, input int nbeats, input logic [39:0] sq);
        logic [7:0] t;
        int j;
        fb.delete();
        for (int i = 0; i < 48 || i < nbeats*8; i++) fb.push_back(8'($urandom));
        for (int i = 0; i < 6; i++) fb[i] = (kind == 2) ? 8'hFF : MAC[8*(5-i) +: 8];
        fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[23] = 8'd17;
        for (int i = 0; i < 4; i++) fb[30+i] = IPA[8*(3-i) +: 8];
        fb[36] = UPORT[15:8]; fb[37] = UPORT[7:0];
        t = fb[42]; t[7:5] = 3'b001; fb[42] = t;
        for (int i = 0; i < 5; i++) fb[43+i] = sq[8*(4-i) +: 8];
        j = int'($urandom_range(0, 5));
        case (kind)
            1: fb[j] = fb[j] ^ 8'h10;
            3: fb[12] = 8'h86;
            4: fb[14] = 8'h46;
            5: fb[23] = 8'd6;
            6: fb[30 + (j % 4)] = fb[30 + (j % 4)] ^ 8'h80;
            7: begin fb[36] = 8'h12; fb[37] = 8'h34; end
            8: begin t = fb[42]; t[7:5] = 3'b010; fb[42] = t; end
            default: ;
        endcase
        while (fb.size() > nbeats*8) void'(fb.pop_back());
        nb = nbeats;
    endtask

    // acceptance straight from the header rules, on the byte image
    function automatic bit model_ok();
        logic [47:0] dst;
        logic [7:0]  v;
        if (fb.size() <= 48) return 1'b0;
        dst = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
        v = fb[42];
        return ((dst == MAC) || (dst == 48'hFFFF_FFFF_FFFF)) && ({fb[12], fb[13]} == 16'h0800)
            && (fb[14] == 8'h45) && (fb[23] == 8'd17)
            && ({fb[30], fb[31], fb[32], fb[33]} == IPA) && ({fb[36], fb[37]} == UPORT)
            && (v[7:5] == 3'b001);
    endfunction

    function automatic logic [63:0] bdata(input int b);
        logic [63:0] d;
        for (int l = 0; l < 8; l++) d[8*l +: 8] = fb[8*b + l];
        return d;
    endfunction

    function automatic logic [7:0] bkeep(input int b);
        return (b == nb - 1) ? lkeep : 8'hFF;
    endfunction

    function automatic logic buser(input int b);
        return (b == nb - 1) ? luser : 1'b0;
    endfunction

    task automatic send_beat(input int b, input bit hold);
        bit acc;
        int guard;
        if (rnd_gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                full = rnd_full && ($urandom_range(0, 2) == 0);
                idle(1);
            end
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = bdata(b);
        s_axis_tkeep  = bkeep(b);
        s_axis_tlast  = (b == nb - 1);
        s_axis_tuser  = buser(b);
        if (hold) begin
            for (int c = 0; c < 5; c++) begin
                full = 1'b1;
                @(negedge clk156);
                chk("bp_tready", 74'(s_axis_tready), 74'd0);
                chk("bp_wr_en", 74'(wr_en), 74'd0);
                idle(1);
            end
        end
        acc = 0;
        guard = 0;
        while (!acc) begin
            full = rnd_full && ($urandom_range(0, 2) == 0);
            @(negedge clk156);
            acc = s_axis_tready;
            idle(1);
            guard++;
            if (guard > 500) begin
                bad++;
                $display("FAIL beat_timeout: tready never high, want accept");
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "beat accept bound expired");
            end
        end
        s_axis_tvalid = 1'b0;
        full = 1'b0;
    endtask

    task automatic model_frame(input logic [39:0] sq);
        exp_q.delete();
        if (model_ok()) begin
            for (int b = 6; b < nb; b++) exp_q.push_back({bkeep(b), bdata(b), b == nb - 1, buser(b)});
            if (m_prev && sq != m_last + 40'd1) m_gaps++;
            m_last = sq;
            m_prev = 1;
        end else begin
            model_drop++;
        end
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_nwr"}, 74'(got.size()), 74'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk({tag, "_word"}, got[i], exp_q[i]);
        chk({tag, "_drops"}, 74'(drop_count), 74'(model_drop));
`ifdef ETH_DECAP_SEQCHK_EN
        chk({tag, "_gaps"}, 74'(seq_gap_count), 74'(m_gaps));
`endif
        got.delete();
    endtask

    task automatic run_frame(input string tag, input int kind, input int nbeats,
                             input logic [39:0] sq, input int hold_beat);
        build(kind, nbeats, sq);
        model_frame(sq);
        for (int b = 0; b < nb; b++) send_beat(b, b == hold_beat);
        idle(2);
        check_frame(tag);
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        sys_rst_n = 1'b0;
        idle(2);
        sys_rst_n = 1'b1;
        idle(1);
        model_drop = 0; m_gaps = 0; m_prev = 0; m_last = '0;
        got.delete();
    endtask

    initial begin
        sys_rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; full = 1'b0;
        lkeep = 8'hFF; luser = 1'b0;
        @(negedge clk156);
        chk("rst_wr_en", 74'(wr_en), 74'd0);
        chk("rst_din", din, 74'd0);
        chk("rst_tready", 74'(s_axis_tready), 74'd0);
        chk("rst_drops", 74'(drop_count), 74'd0);
        idle(1);
        sys_rst_n = 1'b1;
        idle(1);

        // valid 80-byte frame, seq 1: four full words, tlast only on the fourth
        run_frame("valid80", 0, 10, 40'd1, -1);
        build(0, 10, 40'd2);
        model_frame(40'd2);
        for (int b = 0; b < nb; b++) send_beat(b, 0);
        idle(2);
        chk("v80_nwr", 74'(got.size()), 74'd4);
        for (int i = 0; i < got.size(); i++) begin
            chk("v80_keep", 74'(got[i][73:66]), 74'hFF);
            chk("v80_last", 74'(got[i][1]), 74'(i == 3));
        end
        check_frame("valid80b");

        // wrong UDP dport then a good frame
        run_frame("bad_dport", 7, 10, 40'd3, -1);
        run_frame("after_bad", 0, 10, 40'd4, -1);

        // runt: tlast on beat 3, and a bare 48-byte header
        run_frame("runt4", 0, 4, 40'd5, -1);
        run_frame("runt48", 0, 6, 40'd5, -1);
        run_frame("after_runt", 0, 10, 40'd6, -1);

        // broadcast accepted; 7-beat frame with one payload beat
        run_frame("bcast", 2, 7, 40'd7, -1);

        // FIFO full for five cycles while payload beat 2 is offered
        run_frame("backpr", 0, 10, 40'd8, 8);

        // reset mid-payload: two payload words out, then the tail is a runt
        build(0, 10, 40'd9);
        model_frame(40'd9);
        for (int b = 0; b < 8; b++) send_beat(b, 0);
        s_axis_tvalid = 1'b1; s_axis_tdata = bdata(8); s_axis_tkeep = 8'hFF;
        s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        sys_rst_n = 1'b0;
        @(negedge clk156);
        chk("mid_rst_wr_en", 74'(wr_en), 74'd0);
        chk("mid_rst_drops", 74'(drop_count), 74'd0);
        chk("mid_rst_tready", 74'(s_axis_tready), 74'd0);
        idle(2);
        sys_rst_n = 1'b1;
        chk("mid_rst_nwr", 74'(got.size()), 74'd2);
        for (int i = 0; i < got.size() && i < 2; i++) chk("mid_rst_word", got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
        model_drop = 0; m_gaps = 0; m_prev = 0; m_last = '0;
        send_beat(8, 0);
        send_beat(9, 0);
        idle(2);
        model_drop = 1;
        check_frame("mid_rst_tail");
        run_frame("after_rst", 0, 10, 40'd10, -1);

`ifdef ETH_DECAP_SEQCHK_EN
        do_reset();
        run_frame("seq1", 0, 8, 40'd1, -1);
        run_frame("seq2", 0, 8, 40'd2, -1);
        run_frame("seq4", 0, 8, 40'd4, -1);
        run_frame("seq5", 0, 8, 40'd5, -1);
        chk("seq_gap_1245", 74'(seq_gap_count), 74'd1);
        run_frame("seqmax", 0, 8, 40'hFF_FFFF_FFFF, -1);
        run_frame("seqwrap", 0, 8, 40'd0, -1);
        chk("seq_gap_wrap", 74'(seq_gap_count), 74'd2);
`endif

        // random frames with idle gaps and FIFO backpressure
        rnd_gaps = 1;
        rnd_full = 1;
        sq_next = m_last + 40'd1;
        for (int f = 0; f < 40; f++) begin
            int k;
            int n;
            k = int'($urandom_range(0, 9));
            lkeep = 8'hFF >> $urandom_range(0, 7);
            luser = 1'($urandom_range(0, 1));
            if (k == 9) begin
                k = 0;
                n = int'($urandom_range(1, 6));
            end else begin
                n = 6 + int'($urandom_range(1, 5));
            end
            if ($urandom_range(0, 3) == 0) sq_next = {8'($urandom), 32'($urandom)};
            run_frame("rand", k, n, sq_next, -1);
            sq_next = sq_next + 40'd1;
        end

        chk("wr_protocol", 74'(viol), 74'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
